// File: rtl/addr_wb_wu.sv
// Write-back address generator for the LSTM weight-update stage: turns the stream of
// updated weights into sequential weight-memory writes with row-end markers and a done pulse.
module addr_wb_wu #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int TOTAL      = 2809,
    parameter int ROW_LEN    = 53
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_row_end,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overrun
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(ROW_LEN - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_cnt, addr_nxt;
    logic [ADDR_WIDTH-1:0] col_cnt, col_nxt;
    logic                  wr_fire;
    logic                  row_last;
    logic                  last_beat;
    logic                  ovr_set;
    logic                  ovr_clr;

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_cnt;
        col_nxt   = col_cnt;
        wr_fire   = 1'b0;
        ovr_set   = 1'b0;
        ovr_clr   = 1'b0;
        row_last  = (col_cnt == LAST_COL);
        last_beat = (addr_cnt == LAST_ADDR);

        if (abort) begin
            state_nxt = IDLE;
            addr_nxt  = '0;
            col_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    // A beat arriving with start is flagged but never written.
                    if (i_valid) ovr_set = 1'b1;
                    if (start) begin
                        state_nxt = RUN;
                        addr_nxt  = '0;
                        col_nxt   = '0;
                        ovr_clr   = 1'b1;
                    end
                end
                RUN: begin
                    if (i_valid) begin
                        wr_fire = 1'b1;
                        if (last_beat) begin
                            state_nxt = DONE;
                            addr_nxt  = '0;
                            col_nxt   = '0;
                        end else begin
                            addr_nxt = addr_cnt + 1'b1;
                            col_nxt  = row_last ? '0 : col_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                    if (i_valid) ovr_set = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            col_cnt   <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_row_end <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_cnt  <= addr_nxt;
            col_cnt   <= col_nxt;
            o_wr_en   <= wr_fire;
            o_row_end <= wr_fire && (row_last || last_beat);
            if (wr_fire) begin
                o_wr_addr <= addr_cnt;
                o_wr_data <= i_data;
            end
            // Busy covers the DONE cycle so it drops exactly as done rises.
            o_busy <= (state_nxt == RUN) || (state_nxt == DONE);
            o_done <= (state == DONE) && !abort;
            if (ovr_set)
                o_overrun <= 1'b1;
            else if (ovr_clr)
                o_overrun <= 1'b0;
        end
    end

endmodule
